// File: rtl/tm1638_pkg.sv
// Shared TM1638 command encodings, responder state type and key-frame sizing.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int DATA_RD_BIT  = 1;
  localparam int DATA_FIX_BIT = 2;

  localparam int KEY_BITS  = 32;
  localparam int KEY_CNT_W = $clog2(KEY_BITS + 1);
  localparam logic [KEY_CNT_W-1:0] KEY_CNT_DONE = KEY_CNT_W'(KEY_BITS);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_CMD,
    ST_DATA_RX,
    ST_KEY_TX,
    ST_IGNORE
  } rx_state_t;

endpackage

// File: rtl/tm1638_slave_rx_if.sv
// The 3-wire TM1638 link as seen between a driver (master) and this responder (slave).
interface tm1638_slave_rx_if;
  logic stb_i;
  logic sclk_i;
  logic dio_i;
  logic dio_o;
  logic dio_oe;

  modport master (
    output stb_i,
    output sclk_i,
    output dio_i,
    input  dio_o,
    input  dio_oe
  );

  modport slave (
    input  stb_i,
    input  sclk_i,
    input  dio_i,
    output dio_o,
    output dio_oe
  );
endinterface

// File: rtl/tm1638_in_sync.sv
// Brings STB/CLK/DIO into the clk domain and produces single-cycle edge strobes.
module tm1638_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic sclk_i,
  input  logic dio_i,
  output logic stb_o,
  output logic dio_o,
  output logic stb_rise_o,
  output logic stb_fall_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  // Chain resets to 0 so a frame that is mid-flight during reset looks like
  // STB still low; the responder then waits for a genuine STB high.
  logic [2:0] sync_q [SYNC_STAGES];
  logic [1:0] prev_q;
  logic [2:0] sync_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {stb_i, sclk_i, dio_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last[2:1];
    end
  end

  assign sync_last   = sync_q[SYNC_STAGES-1];
  assign stb_o       = sync_last[2];
  assign dio_o       = sync_last[0];
  assign stb_rise_o  =  sync_last[2] & ~prev_q[1];
  assign stb_fall_o  = ~sync_last[2] &  prev_q[1];
  assign sclk_rise_o =  sync_last[1] & ~prev_q[0];
  assign sclk_fall_o = ~sync_last[1] &  prev_q[0];

endmodule

// File: rtl/tm1638_slave_rx.sv
// TM1638 device-side responder: command decode, 16x8 display RAM, key-scan readback.
module tm1638_slave_rx
  import tm1638_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int RAM_DEPTH   = 16,
  localparam int AW          = $clog2(RAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  tm1638_slave_rx_if.slave    link,
  input  logic [KEY_BITS-1:0] keys_i,
  output logic                disp_on,
  output logic [2:0]          brightness,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [7:0]          ram_wdata,
  input  logic [AW-1:0]       rd_addr,
  output logic [7:0]          rd_data,
  output logic                frame_err
);

  function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] a);
    if (a == AW'(RAM_DEPTH - 1)) return '0;
    return a + AW'(1);
  endfunction

  logic stb_s, dio_s, stb_rise, stb_fall, sclk_rise, sclk_fall;

  tm1638_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .stb_i      (link.stb_i),
    .sclk_i     (link.sclk_i),
    .dio_i      (link.dio_i),
    .stb_o      (stb_s),
    .dio_o      (dio_s),
    .stb_rise_o (stb_rise),
    .stb_fall_o (stb_fall),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall)
  );

  rx_state_t             state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            sr_q, sr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  fixed_q, fixed_d;
  logic                  disp_on_q, disp_on_d;
  logic [2:0]            bright_q, bright_d;
  logic [KEY_BITS-1:0]   key_sr_q, key_sr_d;
  logic [KEY_CNT_W-1:0]  key_cnt_q, key_cnt_d;
  logic                  dio_q, dio_d;
  logic                  dio_oe_q, dio_oe_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  ferr_q, ferr_d;
  logic [7:0]            ram_q [RAM_DEPTH];

  logic       capture, byte_end;
  logic [7:0] byte_w;

  // The 7 earlier bits sit in sr_q; the byte is complete with the current DIO bit.
  assign byte_w   = {dio_s, sr_q};
  assign capture  = sclk_rise & ~stb_s &
                    (state_q inside {ST_CMD, ST_DATA_RX, ST_KEY_TX, ST_IGNORE});
  assign byte_end = capture && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    fixed_d   = fixed_q;
    disp_on_d = disp_on_q;
    bright_d  = bright_q;
    key_sr_d  = key_sr_q;
    key_cnt_d = key_cnt_q;
    dio_d     = dio_q;
    dio_oe_d  = dio_oe_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ferr_d    = 1'b0;

    if (state_q == ST_WAIT_IDLE) begin
      if (stb_s) state_d = ST_IDLE;
    end else if (stb_rise) begin
      // Frame end has priority over a coincident clock edge.
      ferr_d    = (bit_cnt_q != 3'd0);
      bit_cnt_d = '0;
      dio_oe_d  = 1'b0;
      dio_d     = 1'b0;
      state_d   = ST_IDLE;
    end else begin
      if (capture) begin
        sr_d      = byte_w[7:1];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (stb_fall) begin
            bit_cnt_d = '0;
            state_d   = ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_end) begin
            case (byte_w[7:6])
              CMD_DATA: begin
                if (byte_w[DATA_RD_BIT]) begin
                  key_sr_d  = keys_i;
                  key_cnt_d = '0;
                  state_d   = ST_KEY_TX;
                end else begin
                  fixed_d = byte_w[DATA_FIX_BIT];
                  state_d = ST_IGNORE;
                end
              end
              CMD_DISP: begin
                disp_on_d = byte_w[3];
                bright_d  = byte_w[2:0];
                state_d   = ST_IGNORE;
              end
              CMD_ADDR: begin
                addr_d  = byte_w[AW-1:0];
                state_d = ST_DATA_RX;
              end
              default: begin
                ferr_d  = 1'b1;
                state_d = ST_IGNORE;
              end
            endcase
          end
        end
        ST_DATA_RX: begin
          if (byte_end) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = byte_w;
            if (!fixed_q) addr_d = addr_next(addr_q);
          end
        end
        ST_KEY_TX: begin
          // Bits change on the falling edge; the driver samples on the rise.
          if (sclk_fall && key_cnt_q != KEY_CNT_DONE) begin
            dio_d     = key_sr_q[0];
            key_sr_d  = key_sr_q >> 1;
            dio_oe_d  = 1'b1;
            key_cnt_d = key_cnt_q + KEY_CNT_W'(1);
          end else if (sclk_rise && key_cnt_q == KEY_CNT_DONE) begin
            dio_oe_d = 1'b0;
            dio_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      addr_q    <= '0;
      fixed_q   <= 1'b0;
      disp_on_q <= 1'b0;
      bright_q  <= '0;
      key_sr_q  <= '0;
      key_cnt_q <= '0;
      dio_q     <= 1'b0;
      dio_oe_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      fixed_q   <= fixed_d;
      disp_on_q <= disp_on_d;
      bright_q  <= bright_d;
      key_sr_q  <= key_sr_d;
      key_cnt_q <= key_cnt_d;
      dio_q     <= dio_d;
      dio_oe_q  <= dio_oe_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ferr_q    <= ferr_d;
    end
  end

  // RAM update shares the edge that raises ram_we, so rd_data agrees with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else if (we_d) begin
      ram_q[waddr_d] <= wdata_d;
    end
  end

  assign link.dio_o  = dio_q;
  assign link.dio_oe = dio_oe_q;
  assign disp_on     = disp_on_q;
  assign brightness  = bright_q;
  assign ram_we      = we_q;
  assign ram_addr    = waddr_q;
  assign ram_wdata   = wdata_q;
  assign rd_data     = ram_q[rd_addr];
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_tm1638_slave_rx.sv
// Driver-model bench for tm1638_slave_rx with a write/key-bit scoreboard.
module tb_tm1638_slave_rx;
  import tm1638_pkg::*;

  localparam int CLK_HALF  = 5;
  localparam int SCLK_HALF = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keys;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int fe_pulses = 0;
  int fe_cycles = 0;
  logic fe_prev = 1'b0;
  logic [11:0] wr_exp;
  logic [11:0] wr_q[$];
  logic        bit_q[$];

  tm1638_slave_rx_if link();

  tm1638_slave_rx dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link),
    .keys_i    (keys),
    .disp_on   (disp_on),
    .brightness(brightness),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  always #CLK_HALF clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and frame_err pulse accounting
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", {31'd0, ram_we}, 32'd0);
      end else begin
        wr_exp = wr_q.pop_front();
        chk("wr_addr_data", {20'd0, ram_addr, ram_wdata}, {20'd0, wr_exp});
      end
    end
    if (frame_err) begin
      fe_cycles++;
      if (!fe_prev) fe_pulses++;
    end
    fe_prev = frame_err;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    link.sclk_i = 1'b0;
    link.dio_i  = b;
    #(SCLK_HALF);
    link.sclk_i = 1'b1;
    #(SCLK_HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic frame_begin();
    link.stb_i = 1'b0;
    #(SCLK_HALF);
  endtask

  task automatic frame_end();
    link.stb_i = 1'b1;
    #(2 * SCLK_HALF);
  endtask

  task automatic one_byte_frame(input logic [7:0] b);
    frame_begin();
    send_byte(b);
    frame_end();
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    int we_before;
    link.stb_i  = 1'b1;
    link.sclk_i = 1'b1;
    link.dio_i  = 1'b0;
    keys        = 32'h8040_2001;
    rd_addr     = '0;
    rst         = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    chk("rst_disp_on", {31'd0, disp_on}, 32'd0);
    chk("rst_brightness", {29'd0, brightness}, 32'd0);
    chk("rst_dio_oe", {31'd0, link.dio_oe}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    peek("rst_ram5", 4'd5, 8'h00);

    // Fixed-address write
    one_byte_frame(8'h44);
    wr_q.push_back({4'd3, 8'hA5});
    frame_begin();
    send_byte(8'hC3);
    send_byte(8'hA5);
    frame_end();
    peek("fixed_ram3", 4'd3, 8'hA5);
    chk("fixed_we_cnt", we_cnt, 1);

    // Auto-increment across the wrap
    one_byte_frame(8'h40);
    frame_begin();
    send_byte(8'hC0);
    for (int i = 0; i <= 16; i++) begin
      wr_q.push_back({4'(i % 16), 8'(i)});
      send_byte(8'(i));
    end
    frame_end();
    chk("inc_we_cnt", we_cnt, 18);
    for (int i = 0; i < 16; i++)
      peek($sformatf("inc_ram%0d", i), 4'(i), (i == 0) ? 8'h10 : 8'(i));

    // Display control
    one_byte_frame(8'h8F);
    chk("disp8F_on", {31'd0, disp_on}, 32'd1);
    chk("disp8F_bright", {29'd0, brightness}, 32'd7);
    one_byte_frame(8'h80);
    chk("disp80_on", {31'd0, disp_on}, 32'd0);
    chk("disp80_bright", {29'd0, brightness}, 32'd0);

    // Key-scan readback
    frame_begin();
    send_byte(8'h42);
    chk("key_oe_before", {31'd0, link.dio_oe}, 32'd0);
    for (int i = 0; i < KEY_BITS; i++) bit_q.push_back(keys[i]);
    link.dio_i = 1'b0;
    for (int i = 0; i < KEY_BITS; i++) begin
      link.sclk_i = 1'b0;
      #(SCLK_HALF);
      chk($sformatf("key_oe%0d", i), {31'd0, link.dio_oe}, 32'd1);
      chk($sformatf("key_bit%0d", i), {31'd0, link.dio_o}, {31'd0, bit_q.pop_front()});
      link.sclk_i = 1'b1;
      #(SCLK_HALF);
    end
    chk("key_oe_after32", {31'd0, link.dio_oe}, 32'd0);
    frame_end();
    chk("key_oe_after_stb", {31'd0, link.dio_oe}, 32'd0);
    chk("key_no_err", fe_pulses, 0);

    // Partial data byte
    we_before = we_cnt;
    frame_begin();
    send_byte(8'hC0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_end();
    chk("part_fe_pulses", fe_pulses, 1);
    chk("part_fe_cycles", fe_cycles, 1);
    chk("part_no_we", we_cnt, we_before);
    peek("part_ram0", 4'd0, 8'h10);

    // Reset in the middle of a data frame
    one_byte_frame(8'h8A);
    chk("disp8A_on", {31'd0, disp_on}, 32'd1);
    chk("disp8A_bright", {29'd0, brightness}, 32'd2);
    wr_q.push_back({4'd0, 8'h11});
    frame_begin();
    send_byte(8'hC0);
    send_byte(8'h11);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_disp_on", {31'd0, disp_on}, 32'd0);
    chk("mrst_bright", {29'd0, brightness}, 32'd0);
    chk("mrst_oe", {31'd0, link.dio_oe}, 32'd0);
    for (int i = 0; i < 16; i++) peek($sformatf("mrst_ram%0d", i), 4'(i), 8'h00);
    we_before = we_cnt;
    send_byte(8'h22);
    send_byte(8'h33);
    frame_end();
    chk("mrst_ignored", we_cnt, we_before);
    wr_q.push_back({4'd0, 8'h55});
    frame_begin();
    send_byte(8'hC0);
    send_byte(8'h55);
    frame_end();
    peek("post_ram0", 4'd0, 8'h55);
    peek("post_ram1", 4'd1, 8'h00);

    chk("sb_empty", wr_q.size(), 0);
    chk("we_total", we_cnt, 20);
    chk("fe_total", fe_pulses, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
